inst_decode: RTL and testbench
==============================

INST_DECODE -- requirements
Module: inst_decode

Interface
REQ-001 SHALL have parameter XLEN, default 64, width of the PC fields.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port flush  in  1  discard all buffered instructions.
REQ-005 SHALL have ports in_valid (in, 1) and in_ready (out, 1), the fetch-side handshake.
REQ-006 SHALL have port in_inst  in  32  raw RV64 instruction.
REQ-007 SHALL have port in_pc  in  XLEN  instruction address.
REQ-008 SHALL have ports out_valid (out, 1) and out_ready (in, 1), the execute-side handshake.
REQ-009 SHALL have decoded output ports, all out: out_opcode (7), out_funct3 (3), out_funct7 (7), out_rd (5), out_rs1 (5), out_rs2 (5), out_imm (20), out_width_32 (1), out_illegal (1), out_pc (XLEN).

Function
REQ-010 SHALL transfer an instruction on an edge where in_valid && in_ready; SHALL transfer out on an edge where out_valid && out_ready.
REQ-011 SHALL buffer in a 2-entry FIFO (head + skid) with states EMPTY, ONE and FULL; in_ready SHALL be a registered signal that is 1 in EMPTY and ONE and 0 in FULL.
REQ-012 SHALL present an instruction accepted at edge N on the outputs after edge N, so latency is 1 cycle; sustained throughput SHALL be 1 per cycle while out_ready=1.
REQ-013 SHALL perform simultaneous accept and release in ONE with no change of state, and the new entry SHALL replace the head.
REQ-014 SHALL preserve program order; output fields SHALL be held stable while out_valid=1 && out_ready=0.
REQ-015 SHALL take out_opcode=inst[6:0], out_rd=inst[11:7], out_funct3=inst[14:12], out_rs1=inst[19:15], out_rs2=inst[24:20], out_funct7=inst[31:25].
REQ-016 SHALL form out_imm for I-type (opcodes 0000011, 0010011, 0011011, 1100111) as {8{inst[31]}, inst[31:20]}.
REQ-017 SHALL form out_imm for S-type as {8{inst[31]}, inst[31:25], inst[11:7]}.
REQ-018 SHALL form out_imm for B-type as {8{inst[31]}, inst[31], inst[7], inst[30:25], inst[11:8]}, i.e. offset[12:1].
REQ-019 SHALL form out_imm for JAL as {inst[31], inst[19:12], inst[20], inst[30:21]}, i.e. offset[20:1]; for LUI and AUIPC as inst[31:12]; for R-type as 0.
REQ-020 SHALL set out_width_32 only for opcodes 0111011 and 0011011.
REQ-021 SHALL set out_illegal=1 when inst[1:0]!=2'b11 or the opcode is outside {0110011, 0111011, 0010011, 0011011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111}.
REQ-022 SHALL also set out_illegal=1 for R-type with funct7 outside {0000000, 0100000, 0000001}, for funct7=0100000 with funct3 not 000/101, and for opcode 0111011 with funct7=0000001 and funct3 001/010/011.
REQ-023 SHALL pass illegal instructions through the pipeline with all raw fields intact and out_illegal=1.
REQ-024 SHALL, on flush=1 at an edge, empty the FIFO and drop any same-cycle input; out_valid=0 and in_ready=1 SHALL follow that edge.

Reset
REQ-025 SHALL, while rst_n=0, force state EMPTY, out_valid=0 and in_ready=0, and zero all output fields.
REQ-026 SHALL raise in_ready to 1 on the first edge after rst_n deasserts; reset mid-stream SHALL discard every buffered entry.

Configuration
REQ-027 SHALL use macro DECODE_M_EXT_EN: when defined, R-type funct7=0000001 is legal, subject to REQ-022; when undefined, every R-type with funct7=0000001 SHALL set out_illegal=1.

Verification
REQ-028 SHALL cover: in_inst=0xFFF00093 (ADDI x1,x0,-1) -> next cycle out_opcode=0010011, out_rd=1, out_imm=0xFFFFF, out_width_32=0, out_illegal=0.
REQ-029 SHALL cover: in_inst=0x123452B7 (LUI x5) -> out_imm=0x12345, out_rd=5.
REQ-030 SHALL cover: in_inst=0x022081B3 (MUL x3,x1,x2) -> out_illegal=0 with DECODE_M_EXT_EN defined, 1 without.
REQ-031 SHALL cover: 3 back-to-back inputs with out_ready=0 for 3 cycles -> in_ready=0 after 2 accepts, then outputs in original order once out_ready=1.
REQ-032 SHALL cover: FULL state, flush=1 together with in_valid=1 -> out_valid=0 next cycle, and the input is never emitted.
REQ-033 SHALL cover: rst_n pulsed low while in ONE -> out_valid=0 immediately and in_ready=1 one edge after release.

Source files
------------

// File: rtl/inst_decode.sv
// RV64 base-ISA instruction decoder behind a 2-entry (head + skid) buffer; optional M extension via DECODE_M_EXT_EN.
// Latency: 1 cycle from an accepted instruction to its decoded fields on the outputs; 1 instruction/cycle sustained.
// Backpressure: registered in_ready drops only when both entries are occupied; outputs hold while out_ready=0.
module inst_decode #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [19:0]     out_imm,
    output logic            out_width_32,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Decoded record; decoding happens before the buffer so entries hold final fields.
    typedef struct packed {
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [19:0]     imm;
        logic            width_32;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } dec_t;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_in_ready;
    dec_t   r_head;
    dec_t   r_skid;
    dec_t   w_dec;
    logic   w_legal_op;
    logic   w_rtype_ill;
    logic   w_in_fire;
    logic   w_out_fire;
    logic   w_head_from_new;
    logic   w_head_from_skid;
    logic   w_skid_load;

    assign in_ready   = r_in_ready;
    assign out_valid  = (r_state != S_EMPTY);
    assign w_in_fire  = in_valid && r_in_ready;
    assign w_out_fire = out_valid && out_ready;

    // Decode the incoming instruction: raw fields, immediate by format, legality.
    always_comb begin
        w_dec        = '0;
        w_legal_op   = 1'b0;
        w_rtype_ill  = 1'b0;
        w_dec.opcode = in_inst[6:0];
        w_dec.rd     = in_inst[11:7];
        w_dec.funct3 = in_inst[14:12];
        w_dec.rs1    = in_inst[19:15];
        w_dec.rs2    = in_inst[24:20];
        w_dec.funct7 = in_inst[31:25];
        w_dec.pc     = in_pc;
        case (in_inst[6:0])
            OP_LOAD, OP_IMM, OP_IMM32, OP_JALR: begin
                w_legal_op = 1'b1;
                w_dec.imm  = {{8{in_inst[31]}}, in_inst[31:20]};
            end
            OP_STORE: begin
                w_legal_op = 1'b1;
                w_dec.imm  = {{8{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            OP_BRANCH: begin
                w_legal_op = 1'b1;
                w_dec.imm  = {{8{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8]};
            end
            OP_JAL: begin
                w_legal_op = 1'b1;
                w_dec.imm  = {in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21]};
            end
            OP_LUI, OP_AUIPC: begin
                w_legal_op = 1'b1;
                w_dec.imm  = in_inst[31:12];
            end
            OP_REG, OP_REG32: w_legal_op = 1'b1;
            default: w_legal_op = 1'b0;
        endcase
        if (in_inst[6:0] == OP_REG || in_inst[6:0] == OP_REG32) begin
            case (in_inst[31:25])
                7'b0000000: w_rtype_ill = 1'b0;
                // SUB/SRA family exists only for funct3 000 and 101.
                7'b0100000: w_rtype_ill = (in_inst[14:12] != 3'b000) && (in_inst[14:12] != 3'b101);
`ifdef DECODE_M_EXT_EN
                // RV64M word ops have no MULH/MULHSU/MULHU forms.
                7'b0000001: w_rtype_ill = (in_inst[6:0] == OP_REG32) &&
                                          (in_inst[14:12] >= 3'b001) && (in_inst[14:12] <= 3'b011);
`else
                7'b0000001: w_rtype_ill = 1'b1;
`endif
                default:    w_rtype_ill = 1'b1;
            endcase
        end
        w_dec.width_32 = (in_inst[6:0] == OP_REG32) || (in_inst[6:0] == OP_IMM32);
        w_dec.illegal  = (in_inst[1:0] != 2'b11) || !w_legal_op || w_rtype_ill;
    end

    // Next-state and buffer steering; flush overrides everything including a same-cycle accept.
    always_comb begin
        w_state_nxt      = r_state;
        w_head_from_new  = 1'b0;
        w_head_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt     = S_ONE;
                    w_head_from_new = 1'b1;
                end
            end
            S_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_head_from_new = 1'b1;
                end else if (w_in_fire) begin
                    w_state_nxt = S_FULL;
                    w_skid_load = 1'b1;
                end else if (w_out_fire) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_out_fire) begin
                    w_state_nxt      = S_ONE;
                    w_head_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
        if (flush) begin
            w_state_nxt      = S_EMPTY;
            w_head_from_new  = 1'b0;
            w_head_from_skid = 1'b0;
            w_skid_load      = 1'b0;
        end
    end

    // State register and registered in_ready (low while in reset and while FULL).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != S_FULL);
        end
    end

    // Head and skid storage; zeroed in reset so output fields read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (w_head_from_new) begin
                r_head <= w_dec;
            end else if (w_head_from_skid) begin
                r_head <= r_skid;
            end
            if (w_skid_load) begin
                r_skid <= w_dec;
            end
        end
    end

    assign out_opcode   = r_head.opcode;
    assign out_funct3   = r_head.funct3;
    assign out_funct7   = r_head.funct7;
    assign out_rd       = r_head.rd;
    assign out_rs1      = r_head.rs1;
    assign out_rs2      = r_head.rs2;
    assign out_imm      = r_head.imm;
    assign out_width_32 = r_head.width_32;
    assign out_illegal  = r_head.illegal;
    assign out_pc       = r_head.pc;

endmodule

// File: tb/tb_inst_decode.sv
// Self-checking bench for inst_decode: reset, directed decode table, buffer corner sequences, random traffic.
// Reference model: queue of accepted instructions plus a decoder written from the ISA immediate/legality rules.
// Inputs driven 1ns after the rising edge; outputs sampled before the next edge.
module tb_inst_decode;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [19:0] out_imm;
    logic        out_width_32;
    logic        out_illegal;
    logic [63:0] out_pc;
    logic [53:0] dut_fields;

    int checks = 0;
    int errors = 0;

    inst_decode #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .out_width_32(out_width_32), .out_illegal(out_illegal), .out_pc(out_pc)
    );

    assign dut_fields = {out_opcode, out_funct3, out_funct7, out_rd, out_rs1, out_rs2,
                         out_imm, out_width_32, out_illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] LEGAL_OPS [11] = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h23,
                                               7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

`ifdef DECODE_M_EXT_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } ent_t;

    typedef struct {
        logic [31:0] inst;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [19:0] imm;
        bit          w32;
        bit          ill;
    } vec_t;

    ent_t        q[$];
    logic [31:0] emitted[$];
    bit          m_rdy;
    vec_t        tbl[12];

    // Reference decoder: immediates as sign-extended offsets, legality from the opcode list and R-type rules.
    function automatic logic [53:0] ref_dec(input logic [31:0] x);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [19:0] imm;
        int          v;
        bit          legal;
        bit          ill;
        bit          w32;
        op    = x[6:0];
        f3    = x[14:12];
        f7    = x[31:25];
        imm   = '0;
        legal = 1'b0;
        for (int i = 0; i < 11; i++) if (op == LEGAL_OPS[i]) legal = 1'b1;
        case (op)
            7'h03, 7'h13, 7'h1B, 7'h67: begin v = $signed(x[31:20]); imm = v[19:0]; end
            7'h23: begin v = $signed({x[31:25], x[11:7]}); imm = v[19:0]; end
            7'h63: begin v = $signed({x[31], x[7], x[30:25], x[11:8], 1'b0}); v = v >>> 1; imm = v[19:0]; end
            7'h6F: begin v = $signed({x[31], x[19:12], x[20], x[30:21], 1'b0}); v = v >>> 1; imm = v[19:0]; end
            7'h37, 7'h17: imm = x[31:12];
            default: imm = '0;
        endcase
        ill = (x[1:0] != 2'b11) || !legal;
        if (op == 7'h33 || op == 7'h3B) begin
            if (f7 == 7'h20) begin
                if (!(f3 == 3'd0 || f3 == 3'd5)) ill = 1'b1;
            end else if (f7 == 7'h01) begin
                if (!M_EN) ill = 1'b1;
                else if (op == 7'h3B && f3 >= 3'd1 && f3 <= 3'd3) ill = 1'b1;
            end else if (f7 != 7'h00) begin
                ill = 1'b1;
            end
        end
        w32 = (op == 7'h3B) || (op == 7'h1B);
        return {op, f3, f7, x[11:7], x[19:15], x[24:20], imm, w32, ill};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // One clock of stimulus: check outputs against the model, clock, then advance the model.
    task automatic cycle(input bit iv, input logic [31:0] inst, input logic [63:0] pc,
                         input bit ordy, input bit fl);
        bit   in_fire;
        bit   out_fire;
        ent_t e;
        in_valid  = iv;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        #1;
        chk("in_ready", in_ready, m_rdy);
        chk("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("fields", dut_fields, ref_dec(q[0].inst));
            chk("pc", out_pc, q[0].pc);
        end
        in_fire  = iv && m_rdy;
        out_fire = (q.size() != 0) && ordy;
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
            m_rdy = 1'b1;
        end else begin
            if (out_fire) begin
                emitted.push_back(q[0].inst);
                void'(q.pop_front());
            end
            if (in_fire) begin
                e.inst = inst;
                e.pc   = pc;
                q.push_back(e);
            end
            m_rdy = (q.size() < 2);
        end
    endtask

    function automatic logic [31:0] gen_inst();
        logic [31:0] x;
        logic [6:0]  f7s [4];
        x = $urandom;
        if ($urandom_range(0, 3) != 0) begin
            x[6:0] = LEGAL_OPS[$urandom_range(0, 10)];
            f7s = '{7'h00, 7'h20, 7'h01, 7'h00};
            f7s[3] = x[31:25];
            x[31:25] = f7s[$urandom_range(0, 3)];
        end
        return x;
    endfunction

    initial begin
        tbl[0]  = '{32'hFFF00093, 7'h13, 5'd1,  20'hFFFFF, 1'b0, 1'b0};
        tbl[1]  = '{32'h123452B7, 7'h37, 5'd5,  20'h12345, 1'b0, 1'b0};
        tbl[2]  = '{32'h022081B3, 7'h33, 5'd3,  20'h00000, 1'b0, !M_EN};
        tbl[3]  = '{32'h40208033, 7'h33, 5'd0,  20'h00000, 1'b0, 1'b0};
        tbl[4]  = '{32'h4020903B, 7'h3B, 5'd0,  20'h00000, 1'b1, 1'b1};
        tbl[5]  = '{32'hFE20AE23, 7'h23, 5'd28, 20'hFFFFC, 1'b0, 1'b0};
        tbl[6]  = '{32'hFE000CE3, 7'h63, 5'd25, 20'hFFFFC, 1'b0, 1'b0};
        tbl[7]  = '{32'h001000EF, 7'h6F, 5'd1,  20'h00400, 1'b0, 1'b0};
        tbl[8]  = '{32'h00000001, 7'h01, 5'd0,  20'h00000, 1'b0, 1'b1};
        tbl[9]  = '{32'h0050811B, 7'h1B, 5'd2,  20'h00005, 1'b1, 1'b0};
        tbl[10] = '{32'h0220903B, 7'h3B, 5'd0,  20'h00000, 1'b1, 1'b1};
        tbl[11] = '{32'h0000007F, 7'h7F, 5'd0,  20'h00000, 1'b0, 1'b1};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
        m_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fields", dut_fields, 0);
        chk("rst_pc", out_pc, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_release_in_ready", in_ready, 1);
        m_rdy = 1'b1;

        // Directed decode vectors streamed back to back with out_ready=1.
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, tbl[i].inst, 64'h1000 + 64'(i * 4), 1'b1, 1'b0);
            chk("tbl_valid", out_valid, 1);
            chk("tbl_opcode", out_opcode, tbl[i].op);
            chk("tbl_rd", out_rd, tbl[i].rd);
            chk("tbl_imm", out_imm, tbl[i].imm);
            chk("tbl_w32", out_width_32, tbl[i].w32);
            chk("tbl_illegal", out_illegal, tbl[i].ill);
            chk("tbl_pc", out_pc, 64'h1000 + 64'(i * 4));
        end
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Stall with three offered inputs, then drain in order.
        emitted.delete();
        cycle(1'b1, 32'h00100093, 64'hA0, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200113, 64'hA4, 1'b0, 1'b0);
        chk("full_in_ready", in_ready, 0);
        cycle(1'b1, 32'h00300193, 64'hA8, 1'b0, 1'b0);
        chk("full_hold_rd", out_rd, 1);
        cycle(1'b1, 32'h00300193, 64'hA8, 1'b1, 1'b0);
        cycle(1'b1, 32'h00300193, 64'hA8, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        chk("order_count", emitted.size(), 3);
        if (emitted.size() == 3) begin
            chk("order_0", emitted[0], 32'h00100093);
            chk("order_1", emitted[1], 32'h00200113);
            chk("order_2", emitted[2], 32'h00300193);
        end

        // Flush in FULL together with a new input.
        cycle(1'b1, 32'h00400213, 64'hB0, 1'b0, 1'b0);
        cycle(1'b1, 32'h00500293, 64'hB4, 1'b0, 1'b0);
        emitted.delete();
        cycle(1'b1, 32'h00A00513, 64'hB8, 1'b0, 1'b1);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        repeat (3) cycle(1'b0, '0, '0, 1'b1, 1'b0);
        chk("flush_nothing_emitted", emitted.size(), 0);

        // Reset pulse while holding one entry.
        cycle(1'b1, 32'h00600313, 64'hC0, 1'b0, 1'b0);
        chk("one_valid", out_valid, 1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_fields", dut_fields, 0);
        q.delete();
        m_rdy = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_in_ready", in_ready, 1);
        chk("postrst_out_valid", out_valid, 0);
        m_rdy = 1'b1;

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 3) != 0, gen_inst(), {$urandom, $urandom},
                  $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
